// File: rtl/multicycle_control.sv
// ============================================================================
// Module   : multicycle_control
// Brief    : Main sequencing FSM of the multi-cycle RV32I core, with a
//            memory-wait watchdog and sticky halt flags.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_control #(
    parameter int MEM_TIMEOUT = 255,
    parameter int TCW         = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instruction_code,
    input  logic        mem_ready,
    input  logic        alu_zero,
    input  logic        alu_lsb,
    output logic [2:0]  ALUOp,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic        pc_write,
    output logic        pc_src,
    output logic        ir_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic        iord,
    output logic        reg_write,
    output logic        mem_to_reg,
    output logic        illegal_instr,
    output logic        bus_error,
    output logic        instr_done
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_EXEC_R    = 4'd2,
        S_EXEC_I    = 4'd3,
        S_EXEC_ADDR = 4'd4,
        S_EXEC_BR   = 4'd5,
        S_MEM_RD    = 4'd6,
        S_MEM_WR    = 4'd7,
        S_WB_ALU    = 4'd8,
        S_WB_MEM    = 4'd9,
        S_HALT      = 4'd10
    } state_t;

    localparam logic [TCW-1:0] c_limit = TCW'(MEM_TIMEOUT);

    state_t         r_state;
    state_t         w_next;
    logic [TCW-1:0] r_cnt;
    logic           w_wait_state;
    logic           w_timeout;
    logic           w_illegal_go;
    logic           w_taken;
    logic [6:0]     w_opcode;
    logic [2:0]     w_funct3;
    logic           w_unused;

    assign w_opcode = instruction_code[6:0];
    assign w_funct3 = instruction_code[14:12];
    assign w_unused = ^{instruction_code[31:15], instruction_code[11:7]};

    assign w_wait_state = (r_state == S_FETCH) || (r_state == S_MEM_RD) ||
                          (r_state == S_MEM_WR);
    // mem_ready arriving on the limit cycle still completes the access
    assign w_timeout    = w_wait_state && !mem_ready && (r_cnt == c_limit);

    always_comb begin
        w_taken = 1'b0;
        case (w_funct3)
            3'b000:          w_taken = alu_zero;
            3'b001:          w_taken = !alu_zero;
            3'b100, 3'b110:  w_taken = alu_lsb;
            3'b101, 3'b111:  w_taken = !alu_lsb;
            default:         w_taken = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_FETCH;
            r_cnt         <= '0;
            illegal_instr <= 1'b0;
            bus_error     <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state)
                r_cnt <= '0;
            else if (w_wait_state && r_cnt != c_limit)
                r_cnt <= r_cnt + 1'b1;
            if (w_illegal_go)
                illegal_instr <= 1'b1;
            if (w_timeout)
                bus_error <= 1'b1;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_illegal_go = 1'b0;
        ALUOp        = 3'b000;
        alu_src_a    = 2'b00;
        alu_src_b    = 2'b00;
        pc_write     = 1'b0;
        pc_src       = 1'b0;
        ir_write     = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        iord         = 1'b0;
        reg_write    = 1'b0;
        mem_to_reg   = 1'b0;
        instr_done   = 1'b0;
        case (r_state)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    w_next   = S_DECODE;
                end else if (w_timeout) begin
                    w_next = S_HALT;
                end
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                case (w_opcode)
                    7'b0110011:             w_next = S_EXEC_R;
                    7'b0010011:             w_next = S_EXEC_I;
                    7'b0000011, 7'b0100011: w_next = S_EXEC_ADDR;
                    7'b1100011:             w_next = S_EXEC_BR;
                    default: begin
                        w_next       = S_HALT;
                        w_illegal_go = 1'b1;
                    end
                endcase
            end
            S_EXEC_R: begin
                ALUOp     = 3'b010;
                alu_src_a = 2'b10;
                w_next    = S_WB_ALU;
            end
            S_EXEC_I: begin
                ALUOp     = 3'b100;
                alu_src_a = 2'b10;
                alu_src_b = 2'b10;
                w_next    = S_WB_ALU;
            end
            S_EXEC_ADDR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b10;
                // opcode bit 5 separates store (0100011) from load (0000011)
                w_next    = instruction_code[5] ? S_MEM_WR : S_MEM_RD;
            end
            S_EXEC_BR: begin
                ALUOp      = 3'b001;
                alu_src_a  = 2'b10;
                pc_write   = w_taken;
                pc_src     = w_taken;
                instr_done = 1'b1;
                w_next     = S_FETCH;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                if (mem_ready)
                    w_next = S_WB_MEM;
                else if (w_timeout)
                    w_next = S_HALT;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
                if (mem_ready) begin
                    instr_done = 1'b1;
                    w_next     = S_FETCH;
                end else if (w_timeout) begin
                    w_next = S_HALT;
                end
            end
            S_WB_ALU: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
                w_next     = S_FETCH;
            end
            S_WB_MEM: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
                w_next     = S_FETCH;
            end
            S_HALT:  w_next = S_HALT;
            default: w_next = S_HALT;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control.sv
// ============================================================================
// Module   : tb_multicycle_control
// Brief    : Directed-vector bench for multicycle_control (MEM_TIMEOUT = 4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multicycle_control;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] instruction_code = 32'h0;
    logic        mem_ready = 1'b0;
    logic        alu_zero = 1'b0;
    logic        alu_lsb = 1'b0;
    logic [2:0]  ALUOp;
    logic [1:0]  alu_src_a, alu_src_b;
    logic        pc_write, pc_src, ir_write, mem_read, mem_write, iord;
    logic        reg_write, mem_to_reg, illegal_instr, bus_error, instr_done;

    int n_vec = 0;
    int n_err = 0;

    multicycle_control #(.MEM_TIMEOUT(4), .TCW(16)) dut (
        .clk(clk), .reset(reset), .instruction_code(instruction_code),
        .mem_ready(mem_ready), .alu_zero(alu_zero), .alu_lsb(alu_lsb),
        .ALUOp(ALUOp), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write),
        .mem_read(mem_read), .mem_write(mem_write), .iord(iord),
        .reg_write(reg_write), .mem_to_reg(mem_to_reg),
        .illegal_instr(illegal_instr), .bus_error(bus_error),
        .instr_done(instr_done)
    );

    always #5 clk = ~clk;

    // {ALUOp, src_a, src_b, pc_write, pc_src, ir_write, mem_read,
    //  mem_write, iord, reg_write, mem_to_reg, instr_done}
    logic [15:0] w_outv;
    assign w_outv = {ALUOp, alu_src_a, alu_src_b, pc_write, pc_src, ir_write,
                     mem_read, mem_write, iord, reg_write, mem_to_reg, instr_done};

    localparam logic [15:0] c_f_wait = 16'b000_00_01_0_0_0_1_0_0_0_0_0;
    localparam logic [15:0] c_f_rdy  = 16'b000_00_01_1_0_1_1_0_0_0_0_0;
    localparam logic [15:0] c_dec    = 16'b000_01_10_0_0_0_0_0_0_0_0_0;
    localparam logic [15:0] c_exr    = 16'b010_10_00_0_0_0_0_0_0_0_0_0;
    localparam logic [15:0] c_exi    = 16'b100_10_10_0_0_0_0_0_0_0_0_0;
    localparam logic [15:0] c_exa    = 16'b000_10_10_0_0_0_0_0_0_0_0_0;
    localparam logic [15:0] c_br_t   = 16'b001_10_00_1_1_0_0_0_0_0_0_1;
    localparam logic [15:0] c_br_n   = 16'b001_10_00_0_0_0_0_0_0_0_0_1;
    localparam logic [15:0] c_mrd    = 16'b000_00_00_0_0_0_1_0_1_0_0_0;
    localparam logic [15:0] c_mwr_w  = 16'b000_00_00_0_0_0_0_1_1_0_0_0;
    localparam logic [15:0] c_mwr_r  = 16'b000_00_00_0_0_0_0_1_1_0_0_1;
    localparam logic [15:0] c_wba    = 16'b000_00_00_0_0_0_0_0_0_1_0_1;
    localparam logic [15:0] c_wbm    = 16'b000_00_00_0_0_0_0_0_0_1_1_1;
    localparam logic [15:0] c_halt   = 16'h0000;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Set mem_ready, check the outputs mid-cycle, then advance one clock.
    task automatic cyc(input string tag, input logic rdy, input logic [15:0] exp);
        mem_ready = rdy;
        #1;
        check(tag, {16'h0, w_outv}, {16'h0, exp});
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        mem_ready = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic flags(input string tag, input logic ill, input logic be);
        #1;
        check(tag, {30'h0, illegal_instr, bus_error}, {30'h0, ill, be});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "bench timeout");
    end

    initial begin
        @(posedge clk);
        #1;
        do_reset();
        flags("rst_flags", 1'b0, 1'b0);
        mem_ready = 1'b0;
        #1;
        check("rst_outputs", {16'h0, w_outv}, {16'h0, c_f_wait});
        do_reset();

        instruction_code = 32'h002081B3;            // ADD x3,x1,x2
        cyc("add_fetch", 1'b1, c_f_rdy);
        cyc("add_decode", 1'b1, c_dec);
        cyc("add_exec", 1'b1, c_exr);
        cyc("add_wb", 1'b1, c_wba);

        instruction_code = 32'h00108093;            // ADDI x1,x1,1
        cyc("addi_fetch", 1'b1, c_f_rdy);
        cyc("addi_decode", 1'b1, c_dec);
        cyc("addi_exec", 1'b1, c_exi);
        cyc("addi_wb", 1'b1, c_wba);

        instruction_code = 32'h0000A183;            // LW, 3 wait states
        cyc("lw_fetch", 1'b1, c_f_rdy);
        cyc("lw_decode", 1'b1, c_dec);
        cyc("lw_addr", 1'b1, c_exa);
        for (int i = 0; i < 3; i++) cyc("lw_mem_wait", 1'b0, c_mrd);
        cyc("lw_mem_rdy", 1'b1, c_mrd);
        cyc("lw_wb", 1'b1, c_wbm);
        flags("lw_flags", 1'b0, 1'b0);

        instruction_code = 32'h00208463;            // BEQ taken
        alu_zero = 1'b1;
        cyc("beq_t_fetch", 1'b1, c_f_rdy);
        cyc("beq_t_decode", 1'b1, c_dec);
        cyc("beq_taken", 1'b1, c_br_t);
        alu_zero = 1'b0;                            // BEQ not taken
        cyc("beq_n_fetch", 1'b1, c_f_rdy);
        cyc("beq_n_decode", 1'b1, c_dec);
        cyc("beq_not_taken", 1'b1, c_br_n);

        instruction_code = 32'h0020F463;            // BGEU, lsb=1 -> not taken
        alu_lsb = 1'b1;
        cyc("bgeu_fetch", 1'b1, c_f_rdy);
        cyc("bgeu_decode", 1'b1, c_dec);
        cyc("bgeu_not_taken", 1'b1, c_br_n);
        instruction_code = 32'h0020C463;            // BLT, lsb=1 -> taken
        cyc("blt_fetch", 1'b1, c_f_rdy);
        cyc("blt_decode", 1'b1, c_dec);
        cyc("blt_taken", 1'b1, c_br_t);
        alu_lsb = 1'b0;

        instruction_code = 32'h0020A023;            // SW, one wait then ready
        cyc("sw_fetch", 1'b1, c_f_rdy);
        cyc("sw_decode", 1'b1, c_dec);
        cyc("sw_addr", 1'b1, c_exa);
        cyc("sw_mem_wait", 1'b0, c_mwr_w);
        cyc("sw_mem_rdy", 1'b1, c_mwr_r);
        cyc("sw_next_fetch", 1'b0, c_f_wait);

        do_reset();
        instruction_code = 32'h0000007F;            // illegal opcode
        cyc("ill_fetch", 1'b1, c_f_rdy);
        cyc("ill_decode", 1'b1, c_dec);
        flags("ill_flags", 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) cyc("ill_halt", 1'(i & 1), c_halt);
        do_reset();
        flags("ill_cleared", 1'b0, 1'b0);
        cyc("ill_reset_fetch", 1'b0, c_f_wait);

        do_reset();                                 // FETCH timeout
        for (int i = 0; i < 5; i++) cyc("to_fetch_wait", 1'b0, c_f_wait);
        cyc("to_halt", 1'b1, c_halt);
        flags("to_flags", 1'b0, 1'b1);

        do_reset();                                 // ready on the limit cycle
        instruction_code = 32'h002081B3;
        for (int i = 0; i < 4; i++) cyc("lim_fetch_wait", 1'b0, c_f_wait);
        cyc("lim_fetch_rdy", 1'b1, c_f_rdy);
        cyc("lim_decode", 1'b1, c_dec);
        flags("lim_flags", 1'b0, 1'b0);

        do_reset();                                 // reset during MEM_WR
        instruction_code = 32'h0020A023;
        cyc("swr_fetch", 1'b1, c_f_rdy);
        cyc("swr_decode", 1'b1, c_dec);
        cyc("swr_addr", 1'b1, c_exa);
        mem_ready = 1'b0;
        #1;
        check("swr_mem_wr", {16'h0, w_outv}, {16'h0, c_mwr_w});
        do_reset();
        mem_ready = 1'b0;
        #1;
        check("swr_after_reset", {16'h0, w_outv}, {16'h0, c_f_wait});
        flags("swr_flags", 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
